// File: rtl/palette_pkg.sv
// Shared constants for palette_mapper: default sizes, RGB packing helper
// and the 16-entry default palette.
package palette_pkg;

    localparam int DEF_GRAY_W = 4;
    localparam int DEF_CH_W   = 2;

    function automatic logic [5:0] rgb_entry(int r, int g, int b);
        return {r[1:0], g[1:0], b[1:0]};
    endfunction

    localparam logic [5:0] DEF_PAL [16] = '{
        rgb_entry(0, 0, 0), rgb_entry(0, 0, 2),
        rgb_entry(1, 0, 3), rgb_entry(2, 0, 3),
        rgb_entry(3, 2, 3), rgb_entry(3, 0, 2),
        rgb_entry(3, 0, 0), rgb_entry(3, 1, 1),
        rgb_entry(3, 2, 0), rgb_entry(3, 3, 1),
        rgb_entry(2, 3, 1), rgb_entry(0, 3, 0),
        rgb_entry(1, 3, 2), rgb_entry(1, 3, 3),
        rgb_entry(3, 3, 2), rgb_entry(3, 3, 3)
    };

endpackage

// File: rtl/palette_rotator.sv
// Rotation offset register and effective palette index; entry 0 never
// rotates, the other entries cycle through 1..2**GRAY_W-1.
module palette_rotator #(
    parameter int GRAY_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cycle_tick,
    input  logic [GRAY_W-1:0] gray,
    output logic [GRAY_W-1:0] eff
);

    localparam logic [GRAY_W:0] MODV = (GRAY_W+1)'(2**GRAY_W - 1);

    logic [GRAY_W-1:0] offset;
    logic [GRAY_W:0]   sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            offset <= '0;
        end else if (cycle_tick) begin
            offset <= offset + GRAY_W'(1);
        end
    end

    // sum never reaches 2*MODV, so one conditional subtract is the modulo
    always_comb begin
        sum = {1'b0, gray} - (GRAY_W+1)'(1) + {1'b0, offset};
        if (sum >= MODV) begin
            sum = sum - MODV;
        end
        eff = (gray == '0) ? '0 : GRAY_W'(sum) + GRAY_W'(1);
    end

endmodule

// File: rtl/palette_mapper.sv
// Gray-index to RGB palette lookup with one registered output stage.
// Optional rotation is compiled in with macro PALETTE_CYCLE_EN.
module palette_mapper
    import palette_pkg::*;
#(
    parameter int GRAY_W = DEF_GRAY_W,
    parameter int CH_W   = DEF_CH_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [GRAY_W-1:0]   in_gray,
    output logic                in_ready,
    output logic                out_valid,
    output logic [CH_W-1:0]     out_r,
    output logic [CH_W-1:0]     out_g,
    output logic [CH_W-1:0]     out_b,
    input  logic                out_ready,
    input  logic                wr_en,
    input  logic [GRAY_W-1:0]   wr_addr,
    input  logic [3*CH_W-1:0]   wr_data,
    input  logic                cycle_tick
);

    localparam int N  = 2**GRAY_W;
    localparam int EW = 3*CH_W;
    localparam int SH = (GRAY_W >= CH_W) ? GRAY_W - CH_W : 0;

    function automatic logic [EW-1:0] def_entry(int i);
        logic [CH_W-1:0] c;
        c = CH_W'(i >> SH);
        if (GRAY_W == DEF_GRAY_W && CH_W == DEF_CH_W) begin
            return EW'(DEF_PAL[i]);
        end
        return {c, c, c};
    endfunction

    logic [EW-1:0]     pal [N];
    logic [GRAY_W-1:0] eff_idx;
    logic [EW-1:0]     lookup;
    logic              accept;

`ifdef PALETTE_CYCLE_EN
    palette_rotator #(
        .GRAY_W(GRAY_W)
    ) u_rot (
        .clk       (clk),
        .rst_n     (rst_n),
        .cycle_tick(cycle_tick),
        .gray      (in_gray),
        .eff       (eff_idx)
    );
`else
    logic unused_tick;
    assign unused_tick = cycle_tick;
    assign eff_idx     = in_gray;
`endif

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    // write-first: a same-edge write to the looked-up entry wins
    assign lookup   = (wr_en && wr_addr == eff_idx) ? wr_data : pal[eff_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                pal[i] <= def_entry(i);
            end
        end else if (wr_en) begin
            pal[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_r     <= '0;
            out_g     <= '0;
            out_b     <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_r     <= lookup[3*CH_W-1:2*CH_W];
            out_g     <= lookup[2*CH_W-1:CH_W];
            out_b     <= lookup[CH_W-1:0];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_palette_mapper.sv
// Directed self-checking bench for palette_mapper with hand-computed
// expected colours; rotation expectations follow PALETTE_CYCLE_EN.
module tb_palette_mapper;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_gray;
    logic       in_ready;
    logic       out_valid;
    logic [1:0] out_r, out_g, out_b;
    logic       out_ready;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [5:0] wr_data;
    logic       cycle_tick;

    int checks = 0;
    int errors = 0;

    logic [5:0] exp_pal [16] = '{
        6'b000000, 6'b000010, 6'b010011, 6'b100011,
        6'b111011, 6'b110010, 6'b110000, 6'b110101,
        6'b111000, 6'b111101, 6'b101101, 6'b001100,
        6'b011110, 6'b011111, 6'b111110, 6'b111111
    };

    palette_mapper #(.GRAY_W(4), .CH_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_gray   (in_gray),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_r     (out_r),
        .out_g     (out_g),
        .out_b     (out_b),
        .out_ready (out_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cycle_tick(cycle_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int rgb();
        return int'({out_r, out_g, out_b});
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            cycle_tick = 1'b1;
            step();
            cycle_tick = 1'b0;
        end
    endtask

    logic [5:0] exp_g1;

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_gray = '0;
        out_ready = 1'b1;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        cycle_tick = 1'b0;
        #12;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_rgb", rgb(), 0);
        chk("rst_ready", int'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // default palette stream
        for (int g = 0; g < 16; g++) begin
            in_valid = 1'b1;
            in_gray = 4'(g);
            step();
            chk($sformatf("def_v%0d", g), int'(out_valid), 1);
            chk($sformatf("def_rgb%0d", g), rgb(), int'(exp_pal[g]));
        end
        in_valid = 1'b0;
        step();
        chk("drain_valid", int'(out_valid), 0);

        // backpressure
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_gray = 4'd4;
        step();
        in_gray = 4'd5;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", int'(out_valid), 1);
            chk("bp_rgb", rgb(), 6'b111011);
            chk("bp_ready", int'(in_ready), 0);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", int'(in_ready), 1);
        step();
        chk("bp_next_rgb", rgb(), 6'b110010);
        in_valid = 1'b0;
        step();
        chk("bp_drain", int'(out_valid), 0);

        // write-first bypass
        in_valid = 1'b1;
        in_gray = 4'd7;
        wr_en = 1'b1;
        wr_addr = 4'd7;
        wr_data = 6'b010101;
        step();
        wr_en = 1'b0;
        chk("byp_rgb", rgb(), 6'b010101);
        step();
        chk("wr_kept", rgb(), 6'b010101);
        wr_en = 1'b1;
        wr_addr = 4'd8;
        wr_data = 6'b000001;
        in_gray = 4'd9;
        step();
        wr_en = 1'b0;
        chk("wr_other", rgb(), 6'b111101);
        in_gray = 4'd3;
        step();
        in_valid = 1'b0;
        chk("pre_rst_valid", int'(out_valid), 1);

        // asynchronous mid-stream reset
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_valid", int'(out_valid), 0);
        chk("async_rgb", rgb(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1;
        in_gray = 4'd7;
        step();
        chk("post_rst_7", rgb(), 6'b110101);
        in_gray = 4'd8;
        step();
        chk("post_rst_8", rgb(), 6'b111000);
        in_valid = 1'b0;
        step();

        // rotation
        tick(3);
`ifdef PALETTE_CYCLE_EN
        exp_g1 = 6'b111011;
`else
        exp_g1 = 6'b000010;
`endif
        in_valid = 1'b1;
        in_gray = 4'd1;
        step();
        chk("rot_g1", rgb(), int'(exp_g1));
        in_gray = 4'd0;
        step();
        chk("rot_g0", rgb(), 0);
        in_valid = 1'b0;
        step();
        tick(12);
        in_valid = 1'b1;
        in_gray = 4'd5;
        step();
        chk("rot15_g5", rgb(), 6'b110010);
        in_valid = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/palette_mapper.md
PALETTE_MAPPER -- requirements
Module: palette_mapper

Interface
REQ-001 SHALL have parameter GRAY_W, default 4: index width; the palette holds 2**GRAY_W entries.
REQ-002 SHALL have parameter CH_W, default 2: bits per colour channel; each entry is 3*CH_W bits, packed {R,G,B}.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have ports in_valid (input, 1) and in_gray (input, GRAY_W): pixel index stream.
REQ-006 SHALL have port in_ready, output, 1: the pixel is accepted when in_valid and in_ready are both high.
REQ-007 SHALL have ports out_valid (output, 1), out_r, out_g and out_b (each output, CH_W): mapped colour stream.
REQ-008 SHALL have port out_ready, input, 1: downstream accept.
REQ-009 SHALL have ports wr_en (input, 1), wr_addr (input, GRAY_W) and wr_data (input, 3*CH_W): palette write port.
REQ-010 SHALL have port cycle_tick, input, 1: single-cycle pulse that advances the palette rotation. The port is present in every build.

Function
REQ-011 SHALL keep the palette in 2**GRAY_W registers and write wr_data into entry wr_addr on any edge where wr_en is high.
REQ-012 SHALL register the lookup result, so latency is exactly 1 cycle from acceptance to out_valid.
REQ-013 SHALL drive in_ready = !out_valid || out_ready (skid-free, single output stage); throughput is 1 pixel/cycle when out_ready stays high.
REQ-014 SHALL hold out_valid, out_r, out_g and out_b stable while out_valid && !out_ready.
REQ-015 SHALL clear out_valid on a cycle where the output is taken and no new pixel is accepted.
REQ-016 SHALL, when a write and an accepted lookup of the same effective entry occur on the same edge, output the new wr_data (write-first bypass).
REQ-017 SHALL compute the effective index (REQ-024) at acceptance time; a later rotation or write does not alter an already-registered output.
REQ-018 SHALL ignore wr_en writes to nothing other than the addressed entry; any wr_addr value is legal.

Reset
REQ-019 SHALL force out_valid to 0 and out_r, out_g and out_b to 0 while rst_n is low, asynchronously.
REQ-020 SHALL load the default palette on reset. For GRAY_W=4 and CH_W=2, entries 0..15 as RGB digits are: 000,002,103,203,323,302,300,311,320,331,231,030,132,133,332,333. Otherwise entry i has R=G=B equal to the top CH_W bits of i, zero-extended if GRAY_W<CH_W.
REQ-021 SHALL clear the rotation offset to 0 on reset.
REQ-022 SHALL let a reset asserted mid-stream drop the in-flight pixel; the first pixel accepted after deassertion uses the default palette.

Configuration
REQ-023 SHALL support macro PALETTE_CYCLE_EN to compile palette rotation in or out.
REQ-024 SHALL, with PALETTE_CYCLE_EN defined, behave as follows:
- GRAY_W-bit offset register; each cycle_tick increments it, wrapping from 2**GRAY_W-1 to 0.
- effective index = in_gray==0 ? 0 : 1 + ((in_gray-1+offset) mod (2**GRAY_W-1)), so entry 0 (set interior) is never rotated.
- a tick coincident with an accepted pixel takes effect for the next pixel.
REQ-025 SHALL, without PALETTE_CYCLE_EN, have no offset register, ignore cycle_tick, and use effective index = in_gray.

Structure
REQ-026 SHALL place the default-palette constant table, the RGB-digit entry packing helper and the default-parameter constants in shared package palette_pkg.
REQ-027 SHALL implement the rotation logic (offset register plus index computation) as sub-module palette_rotator, instantiated only under PALETTE_CYCLE_EN.

Verification
REQ-028 Reset default: release reset, stream gray 0..15 with out_ready=1 -> outputs match the REQ-020 table, each 1 cycle after acceptance.
REQ-029 Backpressure: accept gray 4, hold out_ready=0 for 5 cycles -> RGB stays 3,2,3 with out_valid=1 and in_ready=0; then raise out_ready -> accepted next cycle.
REQ-030 Write bypass: wr_en=1, wr_addr=7, wr_data=6'b010101 on the same edge as accepting gray 7 -> output R=1, G=1, B=1.
REQ-031 Rotation (macro defined): 3 cycle_tick pulses, then gray 1 and gray 0 -> gray 1 maps to entry 4 (3,2,3); gray 0 maps to 0,0,0. After 15 ticks from reset, gray 5 maps to entry 5.
REQ-032 Rotation (macro undefined): 3 ticks, then gray 1 -> 0,0,2.
REQ-033 Mid-stream reset: assert rst_n low while out_valid=1 -> out_valid=0 immediately, before the next clock edge; the prior palette writes are lost.
